// File: rtl/mc_ctrl_ws.sv
// Multicycle MIPS-subset control FSM with memory wait-state handshake,
// bounded wait timeout and an illegal-opcode / timeout exception state.
module mc_ctrl_ws #(
    parameter int unsigned OPW     = 6,
    parameter int unsigned FW      = 6,
    parameter int unsigned TO_W    = 8,
    parameter int unsigned TIMEOUT = 200,
    parameter int unsigned EXC_EN  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OPW-1:0]  op,
    input  logic [FW-1:0]   funct,
    input  logic            zero,
    input  logic            more,
    input  logic            mem_rdy,
    output logic            mem_req,
    output logic            PCWr,
    output logic            IRWr,
    output logic [1:0]      regdst,
    output logic            alusrc,
    output logic [1:0]      memtoreg,
    output logic            regwe,
    output logic            memwe,
    output logic [1:0]      branch,
    output logic [1:0]      jump,
    output logic [1:0]      extop,
    output logic [1:0]      aluop,
    output logic            exc_pc,
    output logic [1:0]      exc_cause,
    output logic            turn,
    output logic [3:0]      state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1, S_MADR = 4'd2, S_MRD = 4'd3,
        S_LDWB   = 4'd4,  S_MWR    = 4'd5, S_EXE  = 4'd6, S_ALUWB = 4'd7,
        S_BR     = 4'd8,  S_JMP    = 4'd9, S_EXC  = 4'd10
    } state_t;

    localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'h00);
    localparam logic [OPW-1:0] OP_J     = OPW'(6'h02);
    localparam logic [OPW-1:0] OP_JAL   = OPW'(6'h03);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'h04);
    localparam logic [OPW-1:0] OP_BNE   = OPW'(6'h05);
    localparam logic [OPW-1:0] OP_BGTZ  = OPW'(6'h07);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'h08);
    localparam logic [OPW-1:0] OP_ADDIU = OPW'(6'h09);
    localparam logic [OPW-1:0] OP_SLTI  = OPW'(6'h0a);
    localparam logic [OPW-1:0] OP_SLTIU = OPW'(6'h0b);
    localparam logic [OPW-1:0] OP_ORI   = OPW'(6'h0d);
    localparam logic [OPW-1:0] OP_LUI   = OPW'(6'h0f);
    localparam logic [OPW-1:0] OP_LW    = OPW'(6'h23);
    localparam logic [OPW-1:0] OP_SW    = OPW'(6'h2b);
    localparam logic [FW-1:0]  F_JR     = FW'(6'h08);
    localparam logic [FW-1:0]  F_ADDU   = FW'(6'h21);
    localparam logic [FW-1:0]  F_SUBU   = FW'(6'h23);
    localparam logic [FW-1:0]  F_SLT    = FW'(6'h2a);
    localparam logic [FW-1:0]  F_SLTU   = FW'(6'h2b);
    localparam logic [TO_W-1:0] TO_LIM  = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] CNT_MAX = '1;

    state_t          st;
    logic [TO_W-1:0] cnt;
    logic [1:0]      cause;

    logic is_rt, is_jr, is_i, is_ld, is_st, is_beq, is_bne, is_bgtz, is_j, is_jal;
    logic is_br, is_jmp, wait_st, to_hit, dec_on;

    // Instruction class decode from the IR fields
    always_comb begin
        is_rt   = (op == OP_RTYPE) && ((funct == F_ADDU) || (funct == F_SUBU) ||
                                       (funct == F_SLT)  || (funct == F_SLTU));
        is_jr   = (op == OP_RTYPE) && (funct == F_JR);
        is_i    = (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_ORI) ||
                  (op == OP_LUI)  || (op == OP_SLTI)  || (op == OP_SLTIU);
        is_ld   = (op == OP_LW);
        is_st   = (op == OP_SW);
        is_beq  = (op == OP_BEQ);
        is_bne  = (op == OP_BNE);
        is_bgtz = (op == OP_BGTZ);
        is_j    = (op == OP_J);
        is_jal  = (op == OP_JAL);
        is_br   = is_beq | is_bne | is_bgtz;
        is_jmp  = is_j | is_jal | is_jr;
        wait_st = (st == S_FETCH) || (st == S_MRD) || (st == S_MWR);
        to_hit  = (TIMEOUT != 0) && (cnt >= TO_LIM);
        dec_on  = st inside {S_DECODE, S_MADR, S_MRD, S_LDWB, S_MWR,
                             S_EXE, S_ALUWB, S_BR, S_JMP};
    end

    // State, wait counter and sticky cause; mem_rdy beats a same-cycle timeout
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st    <= S_FETCH;
            cnt   <= '0;
            cause <= 2'b00;
        end else if (wait_st && !mem_rdy) begin
            if (to_hit) begin
                st    <= S_EXC;
                cnt   <= '0;
                cause <= 2'b10;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + TO_W'(1);
            end
        end else begin
            cnt <= '0;
            case (st)
                S_FETCH:  st <= S_DECODE;
                S_DECODE: begin
                    if (is_rt || is_i)      st <= S_EXE;
                    else if (is_br)         st <= S_BR;
                    else if (is_jmp)        st <= S_JMP;
                    else if (is_ld || is_st) st <= S_MADR;
                    else if (EXC_EN != 0) begin
                        st    <= S_EXC;
                        cause <= 2'b01;
                    end else                st <= S_FETCH;
                end
                S_MADR:   st <= is_ld ? S_MRD : (is_st ? S_MWR : S_FETCH);
                S_MRD:    st <= S_LDWB;
                S_EXE:    st <= S_ALUWB;
                default:  st <= S_FETCH;
            endcase
        end
    end

    // Datapath controls decoded from state and IR
    always_comb begin
        mem_req  = 1'b0;
        PCWr     = 1'b0;
        IRWr     = 1'b0;
        regdst   = 2'b00;
        alusrc   = 1'b0;
        memtoreg = 2'b00;
        regwe    = 1'b0;
        memwe    = 1'b0;
        branch   = 2'b00;
        jump     = 2'b00;
        extop    = 2'b00;
        aluop    = 2'b00;
        exc_pc   = 1'b0;
        turn     = 1'b0;
        if (dec_on) begin
            regdst = is_rt ? 2'b01 : (is_jal ? 2'b10 : 2'b00);
            alusrc = is_i | is_ld | is_st;
            if (op == OP_LUI)
                extop = 2'b10;
            else if ((op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_SLTI) ||
                     (op == OP_SLTIU) || is_ld || is_st || is_br)
                extop = 2'b01;
            if (is_br || (is_rt && (funct == F_SUBU)))
                aluop = 2'b01;
            else if ((op == OP_ORI) || (op == OP_SLTI) || (op == OP_SLTIU) ||
                     (is_rt && ((funct == F_SLT) || (funct == F_SLTU))))
                aluop = 2'b10;
            branch = is_beq ? 2'b01 : (is_bgtz ? 2'b10 : (is_bne ? 2'b11 : 2'b00));
            jump   = is_j ? 2'b01 : (is_jal ? 2'b10 : (is_jr ? 2'b11 : 2'b00));
        end
        case (st)
            S_FETCH: begin
                mem_req = 1'b1;
                turn    = 1'b1;
                IRWr    = mem_rdy;
                PCWr    = mem_rdy;
            end
            S_MRD:   mem_req = 1'b1;
            S_LDWB: begin
                regwe    = 1'b1;
                memtoreg = 2'b01;
            end
            S_MWR: begin
                mem_req = 1'b1;
                memwe   = 1'b1;
            end
            S_ALUWB: regwe = 1'b1;
            S_BR:    PCWr = (is_beq & zero) | (is_bne & ~zero) | (is_bgtz & more);
            S_JMP: begin
                PCWr = 1'b1;
                if (is_jal) begin
                    regwe    = 1'b1;
                    memtoreg = 2'b10;
                end
            end
            S_EXC: begin
                PCWr   = 1'b1;
                exc_pc = 1'b1;
            end
            default: ;
        endcase
    end

    assign exc_cause = cause;
    assign state     = st;

endmodule

// File: tb/tb_mc_ctrl_ws.sv
// Scoreboard bench for mc_ctrl_ws: a default instance and one with TIMEOUT=4, EXC_EN=0.
module tb_mc_ctrl_ws;

    typedef struct {
        string      nm;
        bit         sel;
        logic [3:0] st;
        logic [5:0] ctl;
        logic [1:0] cause;
        bit         dchk;
        logic [12:0] dec;
    } exp_t;

    logic clk, rst, zero, more, mem_rdy;
    logic [5:0] op, funct;

    logic d_mem_req, d_pcwr, d_irwr, d_alusrc, d_regwe, d_memwe, d_exc_pc, d_turn;
    logic [1:0] d_regdst, d_memtoreg, d_branch, d_jump, d_extop, d_aluop, d_cause;
    logic [3:0] d_state;
    logic t_mem_req, t_pcwr, t_irwr, t_alusrc, t_regwe, t_memwe, t_exc_pc, t_turn;
    logic [1:0] t_regdst, t_memtoreg, t_branch, t_jump, t_extop, t_aluop, t_cause;
    logic [3:0] t_state;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    mc_ctrl_ws u_dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .more(more),
        .mem_rdy(mem_rdy), .mem_req(d_mem_req), .PCWr(d_pcwr), .IRWr(d_irwr),
        .regdst(d_regdst), .alusrc(d_alusrc), .memtoreg(d_memtoreg), .regwe(d_regwe),
        .memwe(d_memwe), .branch(d_branch), .jump(d_jump), .extop(d_extop),
        .aluop(d_aluop), .exc_pc(d_exc_pc), .exc_cause(d_cause), .turn(d_turn),
        .state(d_state)
    );

    mc_ctrl_ws #(.TIMEOUT(4), .EXC_EN(0)) u_to (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .more(more),
        .mem_rdy(mem_rdy), .mem_req(t_mem_req), .PCWr(t_pcwr), .IRWr(t_irwr),
        .regdst(t_regdst), .alusrc(t_alusrc), .memtoreg(t_memtoreg), .regwe(t_regwe),
        .memwe(t_memwe), .branch(t_branch), .jump(t_jump), .extop(t_extop),
        .aluop(t_aluop), .exc_pc(t_exc_pc), .exc_cause(t_cause), .turn(t_turn),
        .state(t_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctl = {mem_req, PCWr, IRWr, regwe, memwe, exc_pc}
    function automatic exp_t mk(string nm, bit sel, int st, logic [5:0] ctl, logic [1:0] cause);
        exp_t e;
        e.nm = nm; e.sel = sel; e.st = 4'(st); e.ctl = ctl; e.cause = cause;
        e.dchk = 1'b0; e.dec = '0;
        return e;
    endfunction

    // dec = {regdst, alusrc, memtoreg, branch, jump, extop, aluop}
    function automatic exp_t dec(exp_t ein, logic [1:0] rd, logic as, logic [1:0] mtr,
                                 logic [1:0] br, logic [1:0] jp, logic [1:0] ex, logic [1:0] ao);
        exp_t e;
        e = ein;
        e.dchk = 1'b1;
        e.dec = {rd, as, mtr, br, jp, ex, ao};
        return e;
    endfunction

    task automatic cyc(input logic r, input logic mr);
        @(posedge clk);
        #1;
        rst = r;
        mem_rdy = mr;
    endtask

    task automatic push(input exp_t e);
        q.push_back(e);
    endtask

    // Monitor: pops every expectation queued for this cycle and compares mid-cycle
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [3:0] a_st;
            logic [5:0] a_ctl;
            logic [1:0] a_cause;
            logic [12:0] a_dec;
            logic a_turn;
            bit bad;
            e = q.pop_front();
            if (!e.sel) begin
                a_st = d_state; a_cause = d_cause; a_turn = d_turn;
                a_ctl = {d_mem_req, d_pcwr, d_irwr, d_regwe, d_memwe, d_exc_pc};
                a_dec = {d_regdst, d_alusrc, d_memtoreg, d_branch, d_jump, d_extop, d_aluop};
            end else begin
                a_st = t_state; a_cause = t_cause; a_turn = t_turn;
                a_ctl = {t_mem_req, t_pcwr, t_irwr, t_regwe, t_memwe, t_exc_pc};
                a_dec = {t_regdst, t_alusrc, t_memtoreg, t_branch, t_jump, t_extop, t_aluop};
            end
            bad = (a_st !== e.st) || (a_ctl !== e.ctl) || (a_cause !== e.cause) ||
                  (a_turn !== (e.st == 4'd0)) || (e.dchk && (a_dec !== e.dec));
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL %s: got st=%0d ctl=%b cause=%b turn=%b dec=%b, want st=%0d ctl=%b cause=%b dec=%b",
                         e.nm, a_st, a_ctl, a_cause, a_turn, a_dec, e.st, e.ctl, e.cause,
                         e.dchk ? e.dec : a_dec);
            end
        end
    end

    initial begin
        rst = 1'b0; op = 6'h00; funct = 6'h00; zero = 1'b0; more = 1'b0; mem_rdy = 1'b0;

        // reset state
        cyc(0, 0);
        push(dec(mk("reset", 0, 0, 6'b100000, 2'b00), 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        push(mk("reset_to", 1, 0, 6'b100000, 2'b00));

        // lw with 3 fetch waits and 2 read waits
        cyc(1, 0); op = 6'h23; push(mk("lw_f0", 0, 0, 6'b100000, 2'b00));
        cyc(1, 0); push(mk("lw_f1", 0, 0, 6'b100000, 2'b00));
        cyc(1, 0); push(mk("lw_f2", 0, 0, 6'b100000, 2'b00));
        cyc(1, 1); push(mk("lw_f3", 0, 0, 6'b111000, 2'b00));
        cyc(1, 0);
        push(dec(mk("lw_dec", 0, 1, 6'b000000, 2'b00), 2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00));
        push(mk("lw_dec_to_rdy_wins", 1, 1, 6'b000000, 2'b00));
        cyc(1, 0); push(mk("lw_madr", 0, 2, 6'b000000, 2'b00));
        cyc(1, 0); push(mk("lw_mrd0", 0, 3, 6'b100000, 2'b00));
        cyc(1, 0); push(mk("lw_mrd1", 0, 3, 6'b100000, 2'b00));
        cyc(1, 1); push(mk("lw_mrd2", 0, 3, 6'b100000, 2'b00));
        cyc(1, 0);
        push(dec(mk("lw_ldwb", 0, 4, 6'b000100, 2'b00), 2'b00, 1'b1, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00));

        // sw, memory ready immediately
        cyc(1, 1); op = 6'h2b; push(mk("sw_f", 0, 0, 6'b111000, 2'b00));
        cyc(1, 0); push(mk("sw_dec", 0, 1, 6'b000000, 2'b00));
        cyc(1, 0); push(mk("sw_madr", 0, 2, 6'b000000, 2'b00));
        cyc(1, 1); push(mk("sw_mwr", 0, 5, 6'b100010, 2'b00));

        // beq taken, then not taken
        cyc(1, 1); op = 6'h04; zero = 1'b1; push(mk("beq1_f", 0, 0, 6'b111000, 2'b00));
        cyc(1, 0); push(mk("beq1_dec", 0, 1, 6'b000000, 2'b00));
        cyc(1, 0);
        push(dec(mk("beq1_br", 0, 8, 6'b010000, 2'b00), 2'b00, 1'b0, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01));
        cyc(1, 1); zero = 1'b0; push(mk("beq0_f", 0, 0, 6'b111000, 2'b00));
        cyc(1, 0); push(mk("beq0_dec", 0, 1, 6'b000000, 2'b00));
        cyc(1, 0);
        push(dec(mk("beq0_br", 0, 8, 6'b000000, 2'b00), 2'b00, 1'b0, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01));

        // jal
        cyc(1, 1); op = 6'h03; push(mk("jal_f", 0, 0, 6'b111000, 2'b00));
        cyc(1, 0); push(mk("jal_dec", 0, 1, 6'b000000, 2'b00));
        cyc(1, 0);
        push(dec(mk("jal_jmp", 0, 9, 6'b010100, 2'b00), 2'b10, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00));

        // addu
        cyc(1, 1); op = 6'h00; funct = 6'h21; push(mk("addu_f", 0, 0, 6'b111000, 2'b00));
        cyc(1, 0); push(mk("addu_dec", 0, 1, 6'b000000, 2'b00));
        cyc(1, 0);
        push(dec(mk("addu_exe", 0, 6, 6'b000000, 2'b00), 2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        cyc(1, 0); push(mk("addu_wb", 0, 7, 6'b000100, 2'b00));

        // illegal opcode: exception on default instance, NOP on EXC_EN=0 instance
        cyc(1, 1); op = 6'h3f; funct = 6'h00; push(mk("ill_f", 0, 0, 6'b111000, 2'b00));
        cyc(1, 0); push(mk("ill_dec", 0, 1, 6'b000000, 2'b00));
        cyc(1, 0);
        push(dec(mk("ill_exc", 0, 10, 6'b010001, 2'b01), 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        push(mk("ill_nop_to", 1, 0, 6'b100000, 2'b00));

        // async reset in the middle of a read wait
        cyc(1, 1); op = 6'h23; push(mk("rst_f", 0, 0, 6'b111000, 2'b01));
        cyc(1, 0); push(mk("rst_dec", 0, 1, 6'b000000, 2'b01));
        cyc(1, 0); push(mk("rst_madr", 0, 2, 6'b000000, 2'b01));
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0); push(mk("rst_mrd_wait", 0, 3, 6'b100000, 2'b01));
        end
        cyc(0, 0); push(mk("rst_async", 0, 0, 6'b100000, 2'b00));
        cyc(1, 1); push(mk("rst_resume_f", 0, 0, 6'b111000, 2'b00));
        cyc(1, 0); push(mk("rst_resume_dec", 0, 1, 6'b000000, 2'b00));
        cyc(1, 0); push(mk("rst_resume_madr", 0, 2, 6'b000000, 2'b00));
        cyc(1, 1); push(mk("rst_resume_mrd", 0, 3, 6'b100000, 2'b00));
        cyc(1, 0); push(mk("rst_resume_ldwb", 0, 4, 6'b000100, 2'b00));

        // timeout on TIMEOUT=4 instance, then mem_rdy on the limit cycle
        cyc(0, 0); push(mk("to_reset", 1, 0, 6'b100000, 2'b00));
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0); push(mk("to_wait", 1, 0, 6'b100000, 2'b00));
        end
        cyc(1, 0);
        push(mk("to_exc", 1, 10, 6'b010001, 2'b10));
        push(mk("to_default_no_exc", 0, 0, 6'b100000, 2'b00));
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0); push(mk("to2_wait", 1, 0, 6'b100000, 2'b10));
        end
        cyc(1, 1); push(mk("to2_rdy_at_limit", 1, 0, 6'b111000, 2'b10));
        cyc(1, 0); push(mk("to2_dec", 1, 1, 6'b000000, 2'b10));

        cyc(1, 0);
        cyc(1, 0);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
